// File: rtl/bist_fail_logger.sv
// Collects BIST compare results: counts mismatching SRAM reads, logs the first
// failing addresses with their bit syndromes, and issues the final GoNoGo verdict.
module bist_fail_logger #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 4,
    parameter int LOG_DEPTH = 4,
    parameter int CNT_W     = 9
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              CmpValid,
    input  logic [ADDR_W-1:0] CmpAddr,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [DATA_W-1:0] ExpData,
    input  logic              Done,
    output logic              GoNoGo,
    output logic              ResultValid,
    output logic              Busy,
    output logic [CNT_W-1:0]  FailCount,
    output logic              LogValid,
    output logic [ADDR_W-1:0] LogAddr,
    output logic [DATA_W-1:0] LogSyndrome,
    input  logic              LogReady,
    output logic              LogOverflow
);

    localparam int IDX_W   = $clog2(LOG_DEPTH);
    localparam int PTR_W   = IDX_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic               cmp_take;
    logic               fail_p1;
    logic [ADDR_W-1:0]  addr_p1;
    logic [DATA_W-1:0]  syn_p1;
    logic [CNT_W-1:0]   fail_count;
    logic               log_overflow;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] log_mem [LOG_DEPTH];
    logic [ENTRY_W-1:0] head;
    logic               log_valid;
    logic               full;
    logic               pop;
    logic               push;
    logic               drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        sat_inc = (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
    endfunction

    always_comb begin
        state_nxt = state;
        if (Start) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN:   if (Done) state_nxt = S_DRAIN;
                S_DRAIN: state_nxt = S_DONE;
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Compare stage (p1): a Start in the same cycle discards the compare
    assign cmp_take = (state == S_RUN) & CmpValid & ~Start;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) fail_p1 <= 1'b0;
        else          fail_p1 <= cmp_take & (|(ReadData ^ ExpData));
    end

    always_ff @(posedge Clock) begin
        if (cmp_take) begin
            addr_p1 <= CmpAddr;
            syn_p1  <= ReadData ^ ExpData;
        end
    end

    // Update stage: fail counter and fail-log FIFO
    assign log_valid = (wr_ptr != rd_ptr);
    assign full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign pop       = log_valid & LogReady;
    assign push      = fail_p1 & (~full | pop);
    assign drop      = fail_p1 & full & ~pop;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fail_count   <= '0;
            log_overflow <= 1'b0;
        end else if (Start) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fail_count   <= '0;
            log_overflow <= 1'b0;
        end else begin
            if (pop)     rd_ptr       <= rd_ptr + PTR_W'(1);
            if (push)    wr_ptr       <= wr_ptr + PTR_W'(1);
            if (fail_p1) fail_count   <= sat_inc(fail_count);
            if (drop)    log_overflow <= 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (push) log_mem[wr_ptr[IDX_W-1:0]] <= {addr_p1, syn_p1};
    end

    assign head = log_mem[rd_ptr[IDX_W-1:0]];

    // Outputs decode registered state only; head is masked so an empty log reads as zero
    assign ResultValid = (state == S_DONE);
    assign Busy        = (state == S_RUN) | (state == S_DRAIN);
    assign GoNoGo      = ResultValid & (fail_count == '0) & ~log_overflow;
    assign FailCount   = fail_count;
    assign LogOverflow = log_overflow;
    assign LogValid    = log_valid;
    assign LogAddr     = log_valid ? head[ENTRY_W-1:DATA_W] : '0;
    assign LogSyndrome = log_valid ? head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_bist_fail_logger.sv
// Directed-plus-random bench for bist_fail_logger against a queue-based reference model.
module tb_bist_fail_logger;

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;
    localparam int CNT_MAX = 511;
    localparam int DEPTH   = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cmp_valid;
    logic [7:0] cmp_addr;
    logic [3:0] read_data;
    logic [3:0] exp_data;
    logic       done;
    logic       go_nogo;
    logic       result_valid;
    logic       busy;
    logic [8:0] fail_count;
    logic       log_valid;
    logic [7:0] log_addr;
    logic [3:0] log_syndrome;
    logic       log_ready;
    logic       log_overflow;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: run phase, counters and the log as a plain queue
    int          m_phase;
    int          m_count;
    bit          m_ovf;
    bit          m_pend_fail;
    logic [7:0]  m_pend_addr;
    logic [3:0]  m_pend_syn;
    logic [11:0] m_log[$];

    bist_fail_logger dut (
        .Clock(clk), .Reset_n(rst_n), .Start(start), .CmpValid(cmp_valid),
        .CmpAddr(cmp_addr), .ReadData(read_data), .ExpData(exp_data), .Done(done),
        .GoNoGo(go_nogo), .ResultValid(result_valid), .Busy(busy),
        .FailCount(fail_count), .LogValid(log_valid), .LogAddr(log_addr),
        .LogSyndrome(log_syndrome), .LogReady(log_ready), .LogOverflow(log_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_count = 0;
        m_ovf = 0;
        m_pend_fail = 0;
        m_log.delete();
    endtask

    task automatic model_edge();
        bit pop;
        pop = (m_log.size() > 0) && log_ready;
        if (start) begin
            m_count = 0;
            m_ovf = 0;
            m_pend_fail = 0;
            m_log.delete();
            m_phase = P_RUN;
        end else begin
            if (pop) void'(m_log.pop_front());
            if (m_pend_fail) begin
                if (m_count < CNT_MAX) m_count++;
                if (m_log.size() < DEPTH) m_log.push_back({m_pend_addr, m_pend_syn});
                else m_ovf = 1;
            end
            m_pend_fail = (m_phase == P_RUN) && cmp_valid && ((read_data ^ exp_data) != 4'h0);
            m_pend_addr = cmp_addr;
            m_pend_syn  = read_data ^ exp_data;
            if (m_phase == P_RUN && done) m_phase = P_DRAIN;
            else if (m_phase == P_DRAIN) m_phase = P_DONE;
        end
    endtask

    task automatic check_outputs();
        logic [11:0] hd;
        check("result_valid", result_valid, m_phase == P_DONE);
        check("busy", busy, (m_phase == P_RUN) || (m_phase == P_DRAIN));
        check("go_nogo", go_nogo, (m_phase == P_DONE) && (m_count == 0) && !m_ovf);
        check("fail_count", fail_count, m_count);
        check("log_valid", log_valid, m_log.size() > 0);
        check("log_overflow", log_overflow, m_ovf);
        if (m_log.size() > 0) begin
            hd = m_log[0];
            check("log_addr", log_addr, hd[11:4]);
            check("log_syndrome", log_syndrome, hd[3:0]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic do_compare(input logic [7:0] a, input logic [3:0] rd, input logic [3:0] ex, input logic last);
        cmp_valid = 1'b1;
        cmp_addr = a;
        read_data = rd;
        exp_data = ex;
        done = last;
        cycle();
        cmp_valid = 1'b0;
        done = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fail_word(output logic [3:0] rd, output logic [3:0] ex);
        ex = 4'($urandom);
        rd = ex ^ 4'($urandom_range(1, 15));
    endtask

    initial begin
        logic [3:0] rd;
        logic [3:0] ex;
        rst_n = 1'b0;
        start = 1'b0;
        cmp_valid = 1'b0;
        cmp_addr = '0;
        read_data = '0;
        exp_data = '0;
        done = 1'b0;
        log_ready = 1'b0;
        model_reset();
        #2;
        check("rst_go_nogo", go_nogo, 0);
        check("rst_busy", busy, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_log_valid", log_valid, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Clean run: 256 matching compares
        do_start();
        for (int i = 0; i < 256; i++) begin
            ex = 4'($urandom);
            do_compare(8'(i), ex, ex, i == 255);
        end
        idle(2);
        check("clean_result_valid", result_valid, 1);
        check("clean_go_nogo", go_nogo, 1);
        check("clean_log_valid", log_valid, 0);

        // Single fail at 0x3A
        do_start();
        do_compare(8'h3A, 4'hA, 4'h5, 1'b0);
        cycle();
        check("single_count", fail_count, 1);
        check("single_log_valid", log_valid, 1);
        check("single_addr", log_addr, 8'h3A);
        check("single_syn", log_syndrome, 4'hF);
        done = 1'b1;
        cycle();
        done = 1'b0;
        idle(2);
        check("single_result_valid", result_valid, 1);
        check("single_go_nogo", go_nogo, 0);

        // Overflow: six fails with no readout, then drain the log
        do_start();
        for (int i = 0; i < 6; i++) begin
            fail_word(rd, ex);
            do_compare(8'(i), rd, ex, i == 5);
        end
        idle(2);
        check("ovf_count", fail_count, 6);
        check("ovf_flag", log_overflow, 1);
        check("ovf_go_nogo", go_nogo, 0);
        log_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("ovf_pop_addr", log_addr, i);
            cycle();
        end
        log_ready = 1'b0;
        check("ovf_drained", log_valid, 0);

        // Push and pop on the same edge while full
        do_start();
        for (int i = 0; i < 5; i++) begin
            fail_word(rd, ex);
            do_compare(8'h20 + 8'(i), rd, ex, 1'b0);
        end
        log_ready = 1'b1;
        cycle();
        log_ready = 1'b0;
        check("pp_overflow", log_overflow, 0);
        check("pp_head", log_addr, 8'h21);
        log_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            check("pp_order", log_addr, 8'h20 + 8'(i));
            cycle();
        end
        log_ready = 1'b0;
        check("pp_empty", log_valid, 0);

        // Saturation, then a Start mid-run with a coincident failing compare
        do_start();
        for (int i = 0; i < 600; i++) begin
            fail_word(rd, ex);
            log_ready = ($urandom_range(0, 3) == 0);
            do_compare(8'($urandom), rd, ex, 1'b0);
        end
        log_ready = 1'b0;
        cycle();
        check("sat_count", fail_count, CNT_MAX);
        start = 1'b1;
        fail_word(rd, ex);
        do_compare(8'h77, rd, ex, 1'b0);
        start = 1'b0;
        check("restart_count", fail_count, 0);
        check("restart_log_valid", log_valid, 0);
        check("restart_ovf", log_overflow, 0);
        check("restart_busy", busy, 1);
        idle(2);
        check("restart_discard", fail_count, 0);

        // Randomized traffic across all phases
        do_start();
        for (int i = 0; i < 800; i++) begin
            start = ($urandom_range(0, 119) == 0);
            done = ($urandom_range(0, 39) == 0);
            cmp_valid = $urandom_range(0, 1);
            cmp_addr = 8'($urandom);
            exp_data = 4'($urandom);
            read_data = ($urandom_range(0, 3) == 0) ? 4'($urandom) : exp_data;
            log_ready = ($urandom_range(0, 2) == 0);
            cycle();
        end
        start = 1'b0;
        done = 1'b0;
        cmp_valid = 1'b0;
        log_ready = 1'b0;

        // Asynchronous reset between edges with pending log entries
        do_start();
        for (int i = 0; i < 3; i++) begin
            fail_word(rd, ex);
            do_compare(8'h40 + 8'(i), rd, ex, 1'b0);
        end
        cycle();
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_busy", busy, 0);
        check("arst_result_valid", result_valid, 0);
        check("arst_go_nogo", go_nogo, 0);
        check("arst_fail_count", fail_count, 0);
        check("arst_log_valid", log_valid, 0);
        check("arst_log_addr", log_addr, 0);
        check("arst_log_syndrome", log_syndrome, 0);
        check("arst_overflow", log_overflow, 0);
        #1;
        rst_n = 1'b1;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bist_fail_logger.md
# bist_fail_logger

Result-collection stage that sits directly downstream of the 256x4 SRAM read port and the BIST pattern generator. It compares each SRAM read word against the generator's expected word, counts mismatches, and logs the first failing addresses with their bit syndromes in a small FIFO. It produces the final GoNoGo verdict once the generator signals completion.

## Interface
- ADDR_W, 8, SRAM address width
- DATA_W, 4, SRAM word width
- LOG_DEPTH, 4, fail-log FIFO entries; power of two, ≥2
- CNT_W, 9, fail counter width; saturating
- Clock  in  1  single clock; all state updates on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse; clears all results and begins a run
- CmpValid  in  1  ReadData/ExpData/CmpAddr valid this cycle
- CmpAddr  in  ADDR_W  address of the word being compared
- ReadData  in  DATA_W  word returned by the SRAM
- ExpData  in  DATA_W  expected word from the pattern generator
- Done  in  1  one-cycle pulse; generator has issued its last compare
- GoNoGo  out  1  1 = pass; meaningful only while ResultValid=1
- ResultValid  out  1  run finished and results are final
- Busy  out  1  run in progress (RUN or DRAIN)
- FailCount  out  CNT_W  number of mismatching compares, saturating
- LogValid  out  1  FIFO non-empty; LogAddr/LogSyndrome hold the head entry
- LogAddr  out  ADDR_W  failing address at the FIFO head
- LogSyndrome  out  DATA_W  ReadData XOR ExpData at the FIFO head
- LogReady  in  1  pop request; pops when LogValid=1
- LogOverflow  out  1  sticky; a failure was dropped because the FIFO was full

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on Start.
  - RUN → DRAIN on Done.
  - DRAIN → DONE unconditionally after one cycle.
  - DONE → RUN on Start.
  - Start in any state, including RUN and DRAIN, clears FailCount, the FIFO, LogOverflow and the compare stage, then enters RUN.
- Compare stage is a single register. When CmpValid=1 in RUN, it captures CmpAddr, syn = ReadData^ExpData, and fail = |syn.
  - CmpValid is ignored in IDLE, DRAIN and DONE.
  - CmpValid in the same cycle as Done is still captured.
  - CmpValid in the same cycle as Start is discarded.
- Update stage:
  - A registered fail increments FailCount, saturating at 2^CNT_W−1 (511) with no wrap.
  - It also pushes {addr, syn} into the FIFO if the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped and LogOverflow is set.
- FIFO:
  - Circular buffer of LOG_DEPTH entries. Pointers are log2(LOG_DEPTH)+1 bits to distinguish full from empty.
  - Pop occurs on a rising edge where LogValid & LogReady.
  - Push and pop in the same cycle are both performed:
    - when full, the push is accepted and there is no overflow;
    - when empty, the pushed entry becomes visible the cycle after.
  - LogReady while empty is ignored.
  - Readout is allowed in every state.
- GoNoGo = ResultValid & (FailCount==0) & ~LogOverflow.
- ResultValid = (state==DONE).
- Busy = RUN | DRAIN.

## Timing
- Reset (Reset_n=0, asynchronous) forces:
  - state IDLE;
  - GoNoGo=0, ResultValid=0, Busy=0;
  - FailCount=0, LogValid=0, LogAddr=0, LogSyndrome=0, LogOverflow=0;
  - FIFO pointers =0.
- Reset asserted mid-run abandons the run. There is no recovery of partial results.
- Compare sampled at edge k updates FailCount, LogValid and the FIFO at edge k+1. The update is visible in the cycle after edge k+1.
- Start sampled at edge k: Busy=1 and all results cleared after edge k. The first compare is accepted at edge k+1.
- Done sampled at edge k:
  - DRAIN after k; the last compare is committed at k+1.
  - DONE after k+1, so ResultValid and GoNoGo are valid two cycles after the Done edge.
- Outputs are registered or decoded directly from registers. There is no combinational path from inputs to outputs.

## Test plan
- Clean run: Start, 256 compares with ReadData==ExpData, Done → two cycles later ResultValid=1, GoNoGo=1, FailCount=0, LogValid=0.
- Single fail: compare at CmpAddr=0x3A with ReadData=0xA and ExpData=0x5 → next cycle FailCount=1, LogValid=1, LogAddr=0x3A, LogSyndrome=0xF. After Done, GoNoGo=0.
- Overflow: 6 fails at addresses 0x00–0x05 with LogReady=0 → FailCount=6. Four pops return 0x00–0x03, then LogValid=0. LogOverflow=1 and GoNoGo=0.
- Push/pop when full: FIFO full (4), fail arrives on the same edge as a pop → LogOverflow stays 0, count stays 4, and the newest address sits at the tail.
- Saturation and restart: 600 fail compares → FailCount=511. Start mid-RUN → FailCount=0, LogValid=0, LogOverflow=0, Busy=1. A compare coincident with that Start is not counted.
- Async reset: drop Reset_n between clock edges during RUN with pending log entries → all outputs go 0 immediately, without waiting for a clock edge, and state is IDLE.
